// File: rtl/mem_arb_pkg.sv
// Shared constants for the DDR write-port arbiter: FSM encodings, requester
// indices and active-level helpers.
package mem_arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam int REQ_LEFT  = 0;
    localparam int REQ_RIGHT = 1;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/mem_wr_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module mem_wr_arb_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 wr_clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_wr_arb.sv
// Round-robin burst arbiter for the shared DDR write port (left/right camera).
// Define ARB_STATS_EN to compile in the per-requester accepted-word counters.
module mem_wr_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 29,
    parameter int BURST_LEN   = 8,
    parameter int REGION_SIZE = 1 << 20,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic [1:0]            req_n,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            ack,
    output logic [1:0]            gnt,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_wr_rdy,
    output logic [CNT_WIDTH-1:0]  wr_cnt0,
    output logic [CNT_WIDTH-1:0]  wr_cnt1,
    output logic [0:0]            dbg_state
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] REGION_OFS = ADDR_WIDTH'(REGION_SIZE);

    logic [0:0]        state;
    logic              owner;
    logic              last;
    logic [BEAT_W-1:0] beat;

    logic own_req;
    logic own_acc;
    logic pick;

    // Handshake: the owner's word moves to memory in any cycle where the
    // owner holds req_n low and memory raises mem_wr_rdy; ack reports that
    // same cycle and the requester advances on the following edge.
    assign own_req = (req_n[owner] == ASSERT_L);
    assign own_acc = (state == BURST) && own_req && mem_wr_rdy && !reset;

    // With both requesting, whoever did not hold the port last goes next.
    always_comb begin
        pick = 1'b0;
        if ((req_n[REQ_LEFT] == ASSERT_L) && (req_n[REQ_RIGHT] == ASSERT_L)) begin
            pick = ~last;
        end else if (req_n[REQ_LEFT] == ASSERT_L) begin
            pick = 1'(REQ_LEFT);
        end else begin
            pick = 1'(REQ_RIGHT);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'(REQ_LEFT);
            last  <= 1'(REQ_RIGHT);
            beat  <= '0;
        end else if (state == IDLE) begin
            if (req_n != {DEASSERT_L, DEASSERT_L}) begin
                owner <= pick;
                beat  <= '0;
                state <= BURST;
            end
        end else begin
            if (!own_req) begin
                state <= IDLE;
                last  <= owner;
            end else if (own_acc) begin
                beat <= beat + BEAT_W'(1);
                if (beat == LAST_BEAT) begin
                    state <= IDLE;
                    last  <= owner;
                end
            end
        end
    end

    // The reset cycle forces every memory-side output inactive so an
    // in-flight word is neither written nor acknowledged.
    always_comb begin
        gnt       = '0;
        ack       = '0;
        mem_wr_en = DEASSERT_L;
        mem_addr  = '0;
        mem_data  = '0;
        if ((state == BURST) && !reset) begin
            gnt[owner] = ASSERT_H;
            ack[owner] = own_acc;
            mem_wr_en  = req_n[owner];
            mem_data   = owner ? req_data1 : req_data0;
            mem_addr   = owner ? (req_addr1 + REGION_OFS) : req_addr0;
        end
    end

    assign dbg_state = state;

`ifdef ARB_STATS_EN
    mem_wr_arb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
        .wr_clk (wr_clk),
        .reset  (reset),
        .inc    (ack[REQ_LEFT]),
        .cnt    (wr_cnt0)
    );

    mem_wr_arb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
        .wr_clk (wr_clk),
        .reset  (reset),
        .inc    (ack[REQ_RIGHT]),
        .cnt    (wr_cnt1)
    );
`else
    assign wr_cnt0 = '0;
    assign wr_cnt1 = '0;
`endif

endmodule

// File: doc/mem_wr_arb.md
# mem_wr_arb

Two-requester write arbiter sharing the single DDR write port of the Cyclone V GX memory interface between the left and right camera frame buffers. Grants the port round-robin in bursts of up to BURST_LEN words and relocates each requester into its own address region. The memory handshake is passed through combinationally. Sits between the two frame buffer write paths and the memory controller write port, in the wr_clk domain.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 29, memory word address width
- BURST_LEN, 8, maximum accepted words per grant (≥1)
- REGION_SIZE, 1<<20, address offset added for requester 1
- CNT_WIDTH, 16, statistics counter width
- wr_clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_n  in  2  active-low write request; bit0 = left, bit1 = right
- req_addr0, req_addr1  in  ADDR_WIDTH  requester word address, held stable while req_n low
- req_data0, req_data1  in  DATA_WIDTH  requester write data, held stable while req_n low
- ack  out  2  per-requester accept strobe, high in the cycle its word is taken
- gnt  out  2  one-hot current owner, 0 when idle
- mem_wr_en  out  1  active-low write enable to memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_wr_rdy  in  1  memory accepts the word at this edge when mem_wr_en is low
- wr_cnt0, wr_cnt1  out  CNT_WIDTH  accepted-word counters (see Configuration)

## Operation
- States: IDLE, BURST. Registered: state, owner (1 bit), last (1 bit), beat counter (clog2(BURST_LEN)+1 bits).
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester other than last.
  - On grant: set owner, clear beat, go to BURST.
- BURST:
  - gnt[owner] = 1.
  - mem_wr_en = req_n[owner].
  - mem_data = req_data of owner.
  - mem_addr = req_addr of owner + (owner ? REGION_SIZE : 0), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - Accept: req_n[owner]==0 && mem_wr_rdy==1. In that cycle ack[owner]=1 and beat increments.
- Leaving BURST: on an accept with beat==BURST_LEN-1, or when req_n[owner] is high, go to IDLE and set last=owner.
- The non-owner is never acked. Its request waits in place.
- Outside BURST: mem_wr_en=1, gnt=0, ack=0. mem_addr and mem_data are don't-care, driven 0.

## Timing
- Reset values: state=IDLE, last=1 (so left wins first), beat=0, gnt=0, ack=0, mem_wr_en=1, mem_addr=0, mem_data=0, counters=0.
- Grant latency: 1 cycle from req_n falling in IDLE to mem_wr_en low.
- ack is combinational from mem_wr_rdy (same cycle). The requester advances its address/data on the next edge.
- Full burst with mem_wr_rdy held high: BURST_LEN consecutive acks, then exactly 1 IDLE cycle before the next grant.
- Requester drops req_n mid-burst: that cycle has no ack; the arbiter returns to IDLE at the next edge.
- Reset asserted mid-burst: aborted at that edge. ack and mem_wr_en are forced inactive in the reset cycle, and the word is not counted.

## Configuration
- ARB_STATS_EN defined:
  - wr_cnt0/wr_cnt1 increment on each ack of their requester.
  - They saturate at all-ones and clear on reset.
- ARB_STATS_EN undefined: ports remain, tied to 0, and no counter logic is compiled in.

## Structure
- Package mem_arb_pkg holds:
  - state encodings IDLE/BURST
  - requester indices REQ_LEFT=0, REQ_RIGHT=1
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H constants
- One sub-module, mem_wr_arb_sat_cnt: CNT_WIDTH saturating counter with inc and synchronous reset. Instantiated twice, only under ARB_STATS_EN.

## Test plan
- Only left requests, mem_wr_rdy=1, BURST_LEN=8, req_addr0=0x10 incrementing:
  - mem_addr 0x10..0x17 with 8 ack[0] pulses, then 1 idle cycle, then the next burst at 0x18.
- Both request from reset:
  - Left is granted first for 8 words, then right for 8 words.
  - Right's mem_addr = req_addr1 + 0x100000.
  - The grants alternate thereafter.
- mem_wr_rdy low for 3 cycles mid-burst:
  - mem_wr_en stays low, no ack, beat holds.
  - The burst still totals 8 acks.
- Left releases req_n after 3 accepts:
  - Idle for 1 cycle, then right is granted.
  - Left's 4th word is not acked.
- req_addr1 = 2^29-1 with REGION_SIZE=1<<20: mem_addr = 0xFFFFF (wrap).
- Reset pulsed in the 5th beat with ARB_STATS_EN: outputs return to reset values, wr_cnt0=0, and left is granted first afterward.
